dcache_coherence_port: RTL and testbench
========================================

DCACHE_COHERENCE_PORT -- requirements
Module: dcache_coherence_port

Interface
REQ-001 CLK  in  1  single clock; all state updates on rising edge.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 req_valid  in  1  cache requests a 2-word block transfer; held until req_done.
REQ-004 req_write  in  1  1 = writeback of dirty block, 0 = fill.
REQ-005 req_excl  in  1  fill for write (BusRdX); drives ccwrite.
REQ-006 req_addr  in  32  byte address of block; bits [2:0] ignored.
REQ-007 req_wdata  in  64  writeback data {word1, word0}.
REQ-008 req_done  out  1  one-cycle pulse: transfer complete.
REQ-009 fill_data  out  64  fill data {word1, word0}; valid while req_done=1, held until next fill.
REQ-010 snp_hit  in  1  combinational tag hit for ccsnoopaddr, same cycle.
REQ-011 snp_dirty  in  1  hit line is Modified.
REQ-012 snp_data  in  64  hit line data {word1, word0}.
REQ-013 snp_inv  out  1  one-cycle pulse: invalidate hit line.
REQ-014 snp_downgrade  out  1  one-cycle pulse: mark hit line clean/shared.
REQ-015 dREN  out  1  bus read request.
REQ-016 dWEN  out  1  bus write request (own writeback or snoop supply).
REQ-017 daddr  out  32  bus word address.
REQ-018 dstore  out  32  bus write word.
REQ-019 ccwrite  out  1  requester intends to write; peers invalidate.
REQ-020 cctrans  out  1  snoop response in progress.
REQ-021 dwait  in  1  0 = current bus word accepted this cycle.
REQ-022 dload  in  32  bus read word; valid when dwait=0.
REQ-023 ccwait  in  1  controller snooping this cache.
REQ-024 ccinv  in  1  snoop requires invalidation.
REQ-025 ccsnoopaddr  in  32  snooped block address.

Function
REQ-026 FSM states: IDLE, REQ0, REQ1, DONE, SNP_CHK, SNP_W0, SNP_W1, SNP_END.
REQ-027 Block base B = {addr[31:3],3'b000}; word0 at B, word1 at B+4; daddr never wraps beyond B+4.
REQ-028 IDLE: ccwait=1 -> SNP_CHK (priority); else req_valid=1 -> REQ0; else stay.
REQ-029 REQ0/REQ1: dREN=~req_write, dWEN=req_write, ccwrite=req_excl&~req_write, daddr=B / B+4, dstore=word0/word1; advance on dwait=0, capturing dload into fill_data word0/word1.
REQ-030 REQ1 accept -> DONE; DONE: req_done=1 for exactly one cycle, -> IDLE; back-to-back requests need DONE+IDLE gap (min 4 cycles/block at zero wait).
REQ-031 ccwait=1 in REQ0: abort (no word accepted), bus outputs low that cycle, -> SNP_CHK; request restarts at REQ0 after snoop.
REQ-032 ccwait=1 in REQ1: ignored until REQ1 completes (controller holds snoop).
REQ-033 SNP_CHK: cctrans=1; hit&dirty -> SNP_W0; else -> SNP_END.
REQ-034 SNP_W0/W1: cctrans=1, dWEN=1, daddr=base(ccsnoopaddr)/+4, dstore=snp_data word0/word1; advance on dwait=0; W1 accept -> SNP_END.
REQ-035 SNP_END: cctrans=0; snp_inv=hit&ccinv, snp_downgrade=hit&~ccinv&dirty, one cycle; -> IDLE.
REQ-036 ccinv sampled in SNP_CHK and held to SNP_END; ccsnoopaddr latched in SNP_CHK.
REQ-037 Outputs not listed for a state are 0; dREN and dWEN never both 1.

Reset
REQ-038 RST=1: state IDLE, all outputs 0, fill_data 0, latched snoop address/inv 0; RST mid-transfer abandons it, no req_done.
REQ-039 First cycle after RST deasserts behaves as IDLE.

Verification
REQ-040 Fill 0x0000_1004, dwait 0 each word, dload 0xAAAA_0000/0xBBBB_1111 -> daddr 0x1000 then 0x1004; req_done; fill_data 0xBBBB_1111_AAAA_0000.
REQ-041 Excl fill -> ccwrite=1 with dREN both words; writeback 0x2000 -> dWEN, dstore word0/word1, ccwrite=0.
REQ-042 Snoop 0x3008, hit dirty, ccinv=1 -> cctrans 1 through W1, dstore words at 0x3008/0x300C, snp_inv pulse, no snp_downgrade.
REQ-043 Snoop miss -> cctrans one cycle, no dWEN, no pulses.
REQ-044 ccwait rises in REQ0 with dwait=1 -> dREN drops, snoop served, fill restarts at word0 and completes.
REQ-045 RST during SNP_W1 -> next cycle all outputs 0, IDLE.

Source files
------------

// File: rtl/dcache_coherence_port_if.sv
// dcache_coherence_port_if
// Bundles every non-clock signal of the data-cache coherence port. One
// interface carries all three sides of the block:
//   cache side : req_valid/req_write/req_excl/req_addr/req_wdata in,
//                req_done/fill_data out
//   tag lookup : snp_hit/snp_dirty/snp_data in, snp_inv/snp_downgrade out
//   bus side   : dREN/dWEN/daddr/dstore/ccwrite/cctrans out,
//                dwait/dload/ccwait/ccinv/ccsnoopaddr in
// Modport 'master' is the port block itself, which masters the memory bus.
// Modport 'slave' is the environment around it (cache, tags, bus controller).
interface dcache_coherence_port_if;
   logic        req_valid;
   logic        req_write;
   logic        req_excl;
   logic [31:0] req_addr;
   logic [63:0] req_wdata;
   logic        req_done;
   logic [63:0] fill_data;

   logic        snp_hit;
   logic        snp_dirty;
   logic [63:0] snp_data;
   logic        snp_inv;
   logic        snp_downgrade;

   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        ccwrite;
   logic        cctrans;
   logic        dwait;
   logic [31:0] dload;
   logic        ccwait;
   logic        ccinv;
   logic [31:0] ccsnoopaddr;

   modport master (
      input  req_valid, req_write, req_excl, req_addr, req_wdata,
      output req_done, fill_data,
      input  snp_hit, snp_dirty, snp_data,
      output snp_inv, snp_downgrade,
      output dREN, dWEN, daddr, dstore, ccwrite, cctrans,
      input  dwait, dload, ccwait, ccinv, ccsnoopaddr
   );

   modport slave (
      output req_valid, req_write, req_excl, req_addr, req_wdata,
      input  req_done, fill_data,
      output snp_hit, snp_dirty, snp_data,
      input  snp_inv, snp_downgrade,
      input  dREN, dWEN, daddr, dstore, ccwrite, cctrans,
      output dwait, dload, ccwait, ccinv, ccsnoopaddr
   );
endinterface

// File: rtl/dcache_coherence_port.sv
// dcache_coherence_port
// Moves 2-word cache blocks between the data cache and the coherent memory
// bus, and answers snoops from the coherence controller. A request is either
// a fill (bus read, optionally exclusive) or a writeback of a dirty block.
// Snoops take priority over starting a request; a snooped Modified line is
// supplied to the bus as a 2-word write, then invalidated or downgraded.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - dcache_coherence_port_if.master (cache, tag lookup and bus sides)
module dcache_coherence_port (
   input logic                     clk,
   input logic                     rst,
   dcache_coherence_port_if.master bus
);

   typedef enum logic [2:0] {
      IDLE,
      REQ0,
      REQ1,
      DONE,
      SNP_CHK,
      SNP_W0,
      SNP_W1,
      SNP_END
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [63:0] fill_q;
   logic [31:0] snoop_base;
   logic        snoop_inv;

   logic [31:0] req_base;
   logic        unused_addr_bits;

   logic        ren_c;
   logic        wen_c;
   logic [31:0] addr_c;
   logic [31:0] store_c;
   logic        ccwrite_c;
   logic        cctrans_c;
   logic        done_c;
   logic        inv_c;
   logic        downgrade_c;

   // Blocks are 8-byte aligned, so the low three address bits never matter.
   assign req_base         = {bus.req_addr[31:3], 3'b000};
   assign unused_addr_bits = ^{bus.req_addr[2:0], bus.ccsnoopaddr[2:0]};

   // State register plus the data the port must remember across cycles:
   // fill words land in fill_q as each bus read word is accepted (fills only,
   // writebacks leave the last fill intact), and the snooped block address
   // and invalidate request are frozen in SNP_CHK so the controller's
   // values at the start of the snoop govern the whole response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         fill_q     <= 64'h0;
         snoop_base <= 32'h0;
         snoop_inv  <= 1'b0;
      end else begin
         state <= state_next;
         if (state == REQ0 && !bus.ccwait && !bus.dwait && !bus.req_write) begin
            fill_q[31:0] <= bus.dload;
         end
         if (state == REQ1 && !bus.dwait && !bus.req_write) begin
            fill_q[63:32] <= bus.dload;
         end
         if (state == SNP_CHK) begin
            snoop_base <= {bus.ccsnoopaddr[31:3], 3'b000};
            snoop_inv  <= bus.ccinv;
         end
      end
   end

   // Next-state and output decode. Everything defaults low so each state
   // only names what it drives. A snoop arriving in REQ0 wins before any
   // word is accepted and the request restarts from word0 afterwards; once
   // word0 has gone out the request is allowed to finish, because the
   // controller holds its snoop until then.
   always_comb begin
      state_next  = state;
      ren_c       = 1'b0;
      wen_c       = 1'b0;
      addr_c      = 32'h0;
      store_c     = 32'h0;
      ccwrite_c   = 1'b0;
      cctrans_c   = 1'b0;
      done_c      = 1'b0;
      inv_c       = 1'b0;
      downgrade_c = 1'b0;

      case (state)
         IDLE: begin
            if (bus.ccwait) begin
               state_next = SNP_CHK;
            end else if (bus.req_valid) begin
               state_next = REQ0;
            end
         end

         REQ0: begin
            if (bus.ccwait) begin
               state_next = SNP_CHK;
            end else begin
               ren_c     = ~bus.req_write;
               wen_c     = bus.req_write;
               ccwrite_c = bus.req_excl & ~bus.req_write;
               addr_c    = req_base;
               store_c   = bus.req_wdata[31:0];
               if (!bus.dwait) begin
                  state_next = REQ1;
               end
            end
         end

         REQ1: begin
            ren_c     = ~bus.req_write;
            wen_c     = bus.req_write;
            ccwrite_c = bus.req_excl & ~bus.req_write;
            addr_c    = req_base + 32'd4;
            store_c   = bus.req_wdata[63:32];
            if (!bus.dwait) begin
               state_next = DONE;
            end
         end

         DONE: begin
            done_c     = 1'b1;
            state_next = IDLE;
         end

         SNP_CHK: begin
            cctrans_c = 1'b1;
            if (bus.snp_hit && bus.snp_dirty) begin
               state_next = SNP_W0;
            end else begin
               state_next = SNP_END;
            end
         end

         SNP_W0: begin
            cctrans_c = 1'b1;
            wen_c     = 1'b1;
            addr_c    = snoop_base;
            store_c   = bus.snp_data[31:0];
            if (!bus.dwait) begin
               state_next = SNP_W1;
            end
         end

         SNP_W1: begin
            cctrans_c = 1'b1;
            wen_c     = 1'b1;
            addr_c    = snoop_base + 32'd4;
            store_c   = bus.snp_data[63:32];
            if (!bus.dwait) begin
               state_next = SNP_END;
            end
         end

         SNP_END: begin
            inv_c       = bus.snp_hit & snoop_inv;
            downgrade_c = bus.snp_hit & ~snoop_inv & bus.snp_dirty;
            state_next  = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.dREN          = ren_c;
   assign bus.dWEN          = wen_c;
   assign bus.daddr         = addr_c;
   assign bus.dstore        = store_c;
   assign bus.ccwrite       = ccwrite_c;
   assign bus.cctrans       = cctrans_c;
   assign bus.req_done      = done_c;
   assign bus.snp_inv       = inv_c;
   assign bus.snp_downgrade = downgrade_c;
   assign bus.fill_data     = fill_q;

endmodule

// File: tb/tb_dcache_coherence_port.sv
// tb_dcache_coherence_port
// Bench for dcache_coherence_port. A transaction-level reference model
// (which operation is in flight and which beat of it is on the bus) predicts
// every output on every cycle; directed sequences with literal expectations
// pin that model, then randomized cache, snoop and bus traffic exercises it.
module tb_dcache_coherence_port;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dcache_coherence_port_if bus();

   dcache_coherence_port dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checkCount = 0;
   int failCount  = 0;
   bit armed      = 1'b0;

   // Reference model: m_kind 0 = idle, 1 = cache request, 2 = snoop.
   // Request beats: 0,1 = bus words, 2 = completion pulse.
   // Snoop beats:   0 = tag check, 1,2 = supplied words, 3 = response.
   int          m_kind = 0;
   int          m_beat = 0;
   logic [31:0] m_sbase = 32'h0;
   bit          m_sinv = 1'b0;
   logic [63:0] m_fill = 64'h0;

   bit saw_done     = 1'b0;
   bit saw_snp_end  = 1'b0;
   bit snoop_active = 1'b0;
   bit allow_new    = 1'b0;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every cycle: predict outputs from the model, compare all of them, then
   // move the model along using the same inputs the DUT sees at the edge.
   always @(negedge clk) begin
      logic        e_ren, e_wen, e_ccw, e_trans, e_done, e_inv, e_down;
      logic [31:0] e_addr, e_store;
      if (armed) begin
         e_ren = 0; e_wen = 0; e_ccw = 0; e_trans = 0; e_done = 0;
         e_inv = 0; e_down = 0; e_addr = 32'h0; e_store = 32'h0;
         if (m_kind == 1) begin
            if (m_beat == 2) begin
               e_done = 1;
            end else if (!(m_beat == 0 && bus.ccwait)) begin
               e_ren   = !bus.req_write;
               e_wen   = bus.req_write;
               e_ccw   = bus.req_excl && !bus.req_write;
               e_addr  = (bus.req_addr & 32'hFFFF_FFF8) + 32'(4 * m_beat);
               e_store = 32'(bus.req_wdata >> (32 * m_beat));
            end
         end else if (m_kind == 2) begin
            if (m_beat < 3) e_trans = 1;
            if (m_beat == 1 || m_beat == 2) begin
               e_wen   = 1;
               e_addr  = m_sbase + 32'(4 * (m_beat - 1));
               e_store = 32'(bus.snp_data >> (32 * (m_beat - 1)));
            end
            if (m_beat == 3) begin
               e_inv  = bus.snp_hit && m_sinv;
               e_down = bus.snp_hit && !m_sinv && bus.snp_dirty;
            end
         end

         checkOutput("dREN", 64'(bus.dREN), 64'(e_ren));
         checkOutput("dWEN", 64'(bus.dWEN), 64'(e_wen));
         checkOutput("ccwrite", 64'(bus.ccwrite), 64'(e_ccw));
         checkOutput("cctrans", 64'(bus.cctrans), 64'(e_trans));
         checkOutput("req_done", 64'(bus.req_done), 64'(e_done));
         checkOutput("snp_inv", 64'(bus.snp_inv), 64'(e_inv));
         checkOutput("snp_downgrade", 64'(bus.snp_downgrade), 64'(e_down));
         checkOutput("daddr", 64'(bus.daddr), 64'(e_addr));
         checkOutput("dstore", 64'(bus.dstore), 64'(e_store));
         checkOutput("fill_data", bus.fill_data, m_fill);
         checkOutput("ren_wen_exclusive", 64'(bus.dREN & bus.dWEN), 64'h0);

         if (e_done) saw_done = 1'b1;
         if (m_kind == 2 && m_beat == 3) saw_snp_end = 1'b1;

         if (rst) begin
            m_kind = 0; m_beat = 0; m_fill = 64'h0; m_sbase = 32'h0; m_sinv = 1'b0;
         end else if (m_kind == 0) begin
            if (bus.ccwait) begin
               m_kind = 2; m_beat = 0;
            end else if (bus.req_valid) begin
               m_kind = 1; m_beat = 0;
            end
         end else if (m_kind == 1) begin
            if (m_beat == 2) begin
               m_kind = 0;
            end else if (m_beat == 0 && bus.ccwait) begin
               m_kind = 2; m_beat = 0;
            end else if (!bus.dwait) begin
               if (!bus.req_write) m_fill[32 * m_beat +: 32] = bus.dload;
               m_beat++;
            end
         end else begin
            if (m_beat == 0) begin
               m_sbase = bus.ccsnoopaddr & 32'hFFFF_FFF8;
               m_sinv  = bus.ccinv;
               m_beat  = (bus.snp_hit && bus.snp_dirty) ? 1 : 3;
            end else if (m_beat == 3) begin
               m_kind = 0;
            end else if (!bus.dwait) begin
               m_beat++;
            end
         end
      end
   end

   // One cycle of random traffic that still honours the handshakes: the
   // cache holds a request until req_done, the controller holds a snoop
   // (address, hit/dirty/data, ccinv) until its response cycle has passed.
   task automatic applyStimulus();
      bus.dwait = ($urandom_range(0, 2) == 0);
      bus.dload = $urandom;
      if (bus.req_valid && saw_done) bus.req_valid = 1'b0;
      saw_done = 1'b0;
      if (!bus.req_valid && allow_new && $urandom_range(0, 2) == 0) begin
         bus.req_valid = 1'b1;
         bus.req_write = 1'($urandom_range(0, 1));
         bus.req_excl  = 1'($urandom_range(0, 1));
         bus.req_addr  = $urandom;
         bus.req_wdata = {$urandom, $urandom};
      end
      if (snoop_active && saw_snp_end) begin
         bus.ccwait   = 1'b0;
         snoop_active = 1'b0;
      end else if (!snoop_active && allow_new && $urandom_range(0, 9) == 0) begin
         bus.ccwait      = 1'b1;
         snoop_active    = 1'b1;
         bus.ccsnoopaddr = $urandom;
         bus.ccinv       = 1'($urandom_range(0, 1));
         bus.snp_hit     = 1'($urandom_range(0, 1));
         bus.snp_dirty   = 1'($urandom_range(0, 1));
         bus.snp_data    = {$urandom, $urandom};
      end
      saw_snp_end = 1'b0;
   endtask

   initial begin
      bit drained;
      rst = 1'b1;
      bus.req_valid = 0; bus.req_write = 0; bus.req_excl = 0;
      bus.req_addr = 0; bus.req_wdata = 0;
      bus.snp_hit = 0; bus.snp_dirty = 0; bus.snp_data = 0;
      bus.dwait = 1; bus.dload = 0;
      bus.ccwait = 0; bus.ccinv = 0; bus.ccsnoopaddr = 0;

      @(posedge clk);
      armed = 1'b1;
      @(negedge clk);
      checkOutput("reset_fill", bus.fill_data, 64'h0);
      checkOutput("reset_dREN", 64'(bus.dREN), 64'h0);
      step();
      step();
      rst = 1'b0;

      // Plain fill of 0x1004: words from 0x1000 and 0x1004.
      bus.req_valid = 1; bus.req_write = 0; bus.req_excl = 0;
      bus.req_addr = 32'h0000_1004; bus.dwait = 0; bus.dload = 32'hAAAA_0000;
      step();
      @(negedge clk);
      checkOutput("fill_w0_addr", 64'(bus.daddr), 64'h1000);
      checkOutput("fill_w0_ren", 64'(bus.dREN), 64'h1);
      step();
      bus.dload = 32'hBBBB_1111;
      @(negedge clk);
      checkOutput("fill_w1_addr", 64'(bus.daddr), 64'h1004);
      step();
      bus.req_valid = 0;
      @(negedge clk);
      checkOutput("fill_done", 64'(bus.req_done), 64'h1);
      checkOutput("fill_data_lit", bus.fill_data, 64'hBBBB_1111_AAAA_0000);
      step();

      // Exclusive fill: ccwrite accompanies both read words.
      bus.req_valid = 1; bus.req_excl = 1; bus.req_addr = 32'h0000_5000;
      bus.dload = 32'h5555_0000;
      step();
      @(negedge clk);
      checkOutput("excl_w0_ccwrite", 64'(bus.ccwrite), 64'h1);
      checkOutput("excl_w0_ren", 64'(bus.dREN), 64'h1);
      step();
      @(negedge clk);
      checkOutput("excl_w1_ccwrite", 64'(bus.ccwrite), 64'h1);
      step();
      bus.req_valid = 0;
      step();

      // Writeback of 0x2000 (excl left high: ccwrite must stay low).
      bus.req_valid = 1; bus.req_write = 1; bus.req_excl = 1;
      bus.req_addr = 32'h0000_2000; bus.req_wdata = 64'h2222_0002_1111_0001;
      step();
      @(negedge clk);
      checkOutput("wb_w0_wen", 64'(bus.dWEN), 64'h1);
      checkOutput("wb_w0_ren", 64'(bus.dREN), 64'h0);
      checkOutput("wb_w0_ccwrite", 64'(bus.ccwrite), 64'h0);
      checkOutput("wb_w0_store", 64'(bus.dstore), 64'h1111_0001);
      step();
      @(negedge clk);
      checkOutput("wb_w1_addr", 64'(bus.daddr), 64'h2004);
      checkOutput("wb_w1_store", 64'(bus.dstore), 64'h2222_0002);
      step();
      bus.req_valid = 0; bus.req_write = 0; bus.req_excl = 0;
      @(negedge clk);
      checkOutput("wb_keeps_fill", bus.fill_data, 64'h5555_0000_5555_0000);
      step();

      // Snoop hit on a dirty line with invalidate at 0x3008.
      bus.ccwait = 1; bus.ccsnoopaddr = 32'h0000_3008; bus.ccinv = 1;
      bus.snp_hit = 1; bus.snp_dirty = 1; bus.snp_data = 64'hDDDD_0001_CCCC_0000;
      step();
      @(negedge clk);
      checkOutput("snp_chk_trans", 64'(bus.cctrans), 64'h1);
      step();
      @(negedge clk);
      checkOutput("snp_w0_addr", 64'(bus.daddr), 64'h3008);
      checkOutput("snp_w0_store", 64'(bus.dstore), 64'hCCCC_0000);
      checkOutput("snp_w0_wen", 64'(bus.dWEN), 64'h1);
      step();
      @(negedge clk);
      checkOutput("snp_w1_addr", 64'(bus.daddr), 64'h300C);
      checkOutput("snp_w1_trans", 64'(bus.cctrans), 64'h1);
      step();
      bus.ccwait = 0;
      @(negedge clk);
      checkOutput("snp_end_trans", 64'(bus.cctrans), 64'h0);
      checkOutput("snp_end_inv", 64'(bus.snp_inv), 64'h1);
      checkOutput("snp_end_down", 64'(bus.snp_downgrade), 64'h0);
      step();

      // Dirty hit without invalidate: supply then downgrade.
      bus.ccwait = 1; bus.ccinv = 0; bus.ccsnoopaddr = 32'h0000_7010;
      step(); step(); step(); step();
      bus.ccwait = 0;
      @(negedge clk);
      checkOutput("down_end_down", 64'(bus.snp_downgrade), 64'h1);
      checkOutput("down_end_inv", 64'(bus.snp_inv), 64'h0);
      step();

      // Snoop miss: one cycle of cctrans, nothing else.
      bus.ccwait = 1; bus.ccinv = 1; bus.snp_hit = 0; bus.snp_dirty = 0;
      step();
      bus.ccwait = 0;
      @(negedge clk);
      checkOutput("miss_trans", 64'(bus.cctrans), 64'h1);
      step();
      @(negedge clk);
      checkOutput("miss_end_trans", 64'(bus.cctrans), 64'h0);
      checkOutput("miss_end_wen", 64'(bus.dWEN), 64'h0);
      checkOutput("miss_end_inv", 64'(bus.snp_inv), 64'h0);
      step();

      // Snoop arriving during a stalled word0 aborts and restarts the fill.
      bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h0000_4000; bus.dwait = 1;
      step();
      @(negedge clk);
      checkOutput("abort_pre_ren", 64'(bus.dREN), 64'h1);
      step();
      bus.ccwait = 1;
      @(negedge clk);
      checkOutput("abort_ren_low", 64'(bus.dREN), 64'h0);
      checkOutput("abort_addr_low", 64'(bus.daddr), 64'h0);
      step();
      bus.ccwait = 0; bus.dwait = 0; bus.dload = 32'h1234_5678;
      step();
      step();
      step();
      @(negedge clk);
      checkOutput("restart_addr", 64'(bus.daddr), 64'h4000);
      checkOutput("restart_ren", 64'(bus.dREN), 64'h1);
      step();
      bus.dload = 32'h9ABC_DEF0;
      step();
      bus.req_valid = 0;
      @(negedge clk);
      checkOutput("restart_done", 64'(bus.req_done), 64'h1);
      checkOutput("restart_fill", bus.fill_data, 64'h9ABC_DEF0_1234_5678);
      step();

      // Reset while supplying the second snoop word.
      bus.ccwait = 1; bus.ccsnoopaddr = 32'h0000_6000; bus.ccinv = 0;
      bus.snp_hit = 1; bus.snp_dirty = 1;
      step(); step(); step();
      rst = 1; bus.ccwait = 0;
      @(negedge clk);
      checkOutput("rst_w1_wen", 64'(bus.dWEN), 64'h1);
      step();
      rst = 0;
      @(negedge clk);
      checkOutput("rst_after_wen", 64'(bus.dWEN), 64'h0);
      checkOutput("rst_after_trans", 64'(bus.cctrans), 64'h0);
      checkOutput("rst_after_down", 64'(bus.snp_downgrade), 64'h0);
      checkOutput("rst_after_fill", bus.fill_data, 64'h0);

      // Randomized traffic, then drain everything in flight.
      saw_done = 0; saw_snp_end = 0; snoop_active = 0; allow_new = 1;
      for (int i = 0; i < 3000; i++) begin
         step();
         applyStimulus();
      end
      allow_new = 0;
      drained = 0;
      for (int i = 0; i < 400 && !drained; i++) begin
         step();
         applyStimulus();
         if (!bus.req_valid && !snoop_active && m_kind == 0) drained = 1;
      end
      checkCount++;
      if (!drained) begin
         failCount++;
         $display("[TB] FAIL drain_timeout: traffic still pending, expected idle within 400 cycles");
      end
      step();
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
